muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
Iterative multiply/divide sequencer for the execute stage. Runs MIPS MULT/MULTU/DIV/DIVU one bit per cycle and owns the HI/LO registers. It also serves MTHI/MTLO writes. It raises a stall request so the hazard logic freezes the front of the pipeline while a HI/LO consumer waits on a busy unit.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  issue a mul/div op from execute; sampled on the rising edge.
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
srca  input  WIDTH  multiplicand or dividend (rs).
srcb  input  WIDTH  multiplier or divisor (rt).
flush  input  1  abort the in-flight op (branch/exception squash).
hilo_rd  input  1  instruction in execute is MFHI/MFLO.
hi_we  input  1  MTHI write enable.
lo_we  input  1  MTLO write enable.
wdata  input  WIDTH  MTHI/MTLO data.
busy  output  1  op in flight.
stall_req  output  1  freeze request to the hazard unit.
done  output  1  one-cycle pulse after HI/LO are updated by an op.
hi  output  WIDTH  HI register: product upper half or remainder.
lo  output  WIDTH  LO register: product lower half or quotient.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; hi=0, lo=0, busy=0, done=0; all internal accumulators cleared.
- State IDLE:
  - start=1 at an edge latches op, |srca| and |srcb| (magnitudes for signed ops), and the operand signs.
  - Clears the counter and the accumulator, then goes to CALC.
- State CALC: one iteration per cycle for exactly WIDTH cycles.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - After the WIDTH-th iteration, go to FIXUP.
- State FIXUP, one cycle:
  - Negate the product if the operand signs differ.
  - DIV: quotient negated if the signs differ; remainder takes the dividend's sign.
  - Write hi/lo and return to IDLE.
  - done=1 for the following cycle only.
- Latency: start sampled at edge E0; hi/lo updated at edge E(WIDTH+1); done high for the cycle after that edge (E33→E34 for WIDTH=32).
- busy: 1 from the edge after start through the FIXUP cycle; 0 in IDLE.
- stall_req = busy & (hilo_rd | start). A new op or an MF read waits for completion. Combinational from the registered busy.
- start while busy: ignored by the unit; the pipeline is held by stall_req, and the op is reissued once busy falls.
- Divide by zero: no trap; lo = all ones; hi = dividend (srca as issued, sign intact).
- DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- MTHI/MTLO:
  - Write on the edge only when busy=0 and no start in the same cycle.
  - A write while busy is dropped.
  - If start and a write occur together, start wins and the write is dropped.
- flush:
  - Priority over everything except reset.
  - In CALC/FIXUP it returns to IDLE at the next edge; hi/lo are unchanged and no done pulse is produced.
  - flush together with start in IDLE: start is ignored.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values.
- hi/lo are never partially updated; they change only at FIXUP or on an MT write.

Optional Feature:
MULDIV_SIGNED_EN
- Defined: op 01/11 are signed as described above (magnitude iteration plus FIXUP sign correction).
- Undefined: the sign logic is removed; MULT behaves as MULTU and DIV as DIVU. FIXUP still takes one cycle, so latency is identical. The 0x80000000/-1 special case becomes an ordinary unsigned divide: lo = 0, hi = 0x80000000.

Test Plan:
- Reset then MULTU srca=0xFFFFFFFF srcb=0x00000002 → busy for 33 cycles; done at cycle 34; hi=0x00000001, lo=0xFFFFFFFE.
- MULT srca=0xFFFFFFFD (-3) srcb=0x00000007 (signed build) → hi=0xFFFFFFFF, lo=0xFFFFFFEB; in the unsigned build → hi=0x00000006, lo=0xFFFFFFEB.
- DIV srca=0xFFFFFFF9 (-7) srcb=0x00000002 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/0 → lo=0xFFFFFFFF, hi=100.
- DIVU 1000/7, with hilo_rd=1 on cycle 5 → stall_req=1 until FIXUP; then lo=142, hi=6.
- MTHI 0xAAAA in IDLE → hi=0xAAAA. Start MULTU 3×4, assert flush at cycle 10 → busy drops, no done, hi=0xAAAA. MTLO while busy is dropped.
- Assert reset low during CALC of a DIVU → busy=0, hi=lo=0 immediately (before the next edge).

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU sequencer that owns HI/LO and serves MTHI/MTLO.
// Latency: start at edge E0, HI/LO written at E(WIDTH+1), done high for the following cycle.
// Backpressure: no ready handshake; stall_req = busy & (hilo_rd | start) freezes the front end until the unit is idle.
//
// Ports:
//   clk, reset (async, active-low)       clock and reset
//   start, op[1:0], srca, srcb           issue: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   flush                                squash in-flight op (no HI/LO update, no done)
//   hilo_rd                              MFHI/MFLO in execute
//   hi_we, lo_we, wdata                  MTHI/MTLO writes (only when idle and not starting)
//   busy, stall_req, done, hi, lo        status and HI/LO registers
//
// Build option: define MULDIV_SIGNED_EN to make MULT/DIV signed; otherwise they alias MULTU/DIVU.

module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    input  logic             hilo_rd,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]         state_q,   state_d;
    logic [CW-1:0]      cnt_q,     cnt_d;
    logic               is_div_q,  is_div_d;
    logic               neg_res_q, neg_res_d;   // operand signs differ
    logic               neg_rem_q, neg_rem_d;   // dividend was negative
    logic               divz_q,    divz_d;      // divisor was zero
    logic [WIDTH-1:0]   dvd_raw_q, dvd_raw_d;   // dividend as issued, for divide-by-zero HI
    logic [WIDTH-1:0]   opnd_q,    opnd_d;      // multiplicand magnitude or divisor magnitude
    logic [2*WIDTH-1:0] acc_q,     acc_d;
    logic [WIDTH-1:0]   hi_q,      hi_d;
    logic [WIDTH-1:0]   lo_q,      lo_d;
    logic               done_q,    done_d;

    logic               signed_op;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_trial;
    logic               div_ge;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

`ifdef MULDIV_SIGNED_EN
    assign signed_op = op[0];
`else
    // Sign handling folds away: op[0] is only referenced so MULT/DIV alias their unsigned forms.
    assign signed_op = op[0] & 1'b0;
`endif

    assign sign_a = signed_op & srca[WIDTH-1];
    assign sign_b = signed_op & srcb[WIDTH-1];
    assign mag_a  = sign_a ? (~srca + 1'b1) : srca;
    assign mag_b  = sign_b ? (~srcb + 1'b1) : srcb;

    // Shift-add: upper half accumulates the multiplicand when the current multiplier bit
    // (acc[0]) is set, then the whole {carry, upper, lower} word shifts right by one.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: acc = {remainder, dividend/quotient}. The trial remainder is
    // remainder<<1 | next dividend bit; the quotient bit shifts in at the bottom.
    assign div_trial = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_ge    = (div_trial >= {1'b0, opnd_q});
    assign div_diff  = div_trial - {1'b0, opnd_q};
    assign div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], div_ge};

    assign prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    assign quot_fix = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        divz_d    = divz_q;
        dvd_raw_d = dvd_raw_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!flush) begin
                    if (start) begin
                        state_d   = S_CALC;
                        cnt_d     = '0;
                        is_div_d  = op[1];
                        neg_res_d = sign_a ^ sign_b;
                        neg_rem_d = sign_a;
                        divz_d    = (srcb == '0);
                        dvd_raw_d = srca;
                        opnd_d    = op[1] ? mag_b : mag_a;
                        acc_d     = op[1] ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
                    end else begin
                        // MT writes only land when nothing else claims this cycle.
                        if (hi_we) hi_d = wdata;
                        if (lo_we) lo_d = wdata;
                    end
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                state_d = S_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end else if (divz_q) begin
                        hi_d = dvd_raw_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            divz_q    <= 1'b0;
            dvd_raw_q <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            divz_q    <= divz_d;
            dvd_raw_q <= dvd_raw_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign stall_req = busy & (hilo_rd | start);
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule
